// File: rtl/rom_sequencer.sv
// rom_sequencer: steps a ROM address through one pass (up or down) at a
// programmable rate, registering each word read and keeping a running sum.
module rom_sequencer #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned SUM_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             loop,
  output logic [2:0]       rom_adr,
  input  logic [3:0]       rom_data,
  output logic [3:0]       data_out,
  output logic             data_valid,
  output logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned ADR_W = 3;
  localparam int unsigned DAT_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dir_q, dir_d;
  logic               loop_q, loop_d;

  logic               capture_c;
  logic               last_c;

  // Capture fires when the step counter reaches its terminal count; the last
  // address of a pass depends on the latched direction.
  always_comb begin
    capture_c = (cnt_q == CNT_W'(DIV - 1));
    last_c    = dir_q ? (adr_q == ADR_W'(0)) : (adr_q == ADR_W'(7));
  end

  // Next-state and output logic; stop takes priority over a coincident capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    loop_d  = loop_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          adr_d   = dir ? ADR_W'(7) : ADR_W'(0);
          sum_d   = '0;
          cnt_d   = '0;
          dir_d   = dir;
          loop_d  = loop;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (capture_c) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          sum_d   = sum_q + SUM_W'(rom_data);
          cnt_d   = '0;
          // Natural 3-bit wrap gives 7->0 and 0->7 at the end of a pass.
          adr_d   = dir_q ? (adr_q - ADR_W'(1)) : (adr_q + ADR_W'(1));
          if (last_c) begin
            done_d = 1'b1;
            if (!loop_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      loop_q  <= loop_d;
    end
  end

  assign rom_adr    = adr_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign sum        = sum_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: three instances (DIV = 4, 2, 1) each fed by a
// ROM holding word a+1 at address a, checked against a pass-arithmetic model.
module tb_rom_sequencer;

  localparam int NI = 3;

  function automatic int div_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
  endfunction

  logic clk;
  logic reset;
  logic [NI-1:0]      start, stop, dir, loop;
  logic [NI-1:0][2:0] rom_adr;
  logic [NI-1:0][3:0] rom_data;
  logic [NI-1:0][3:0] data_out;
  logic [NI-1:0]      data_valid, busy, done;
  logic [NI-1:0][5:0] sum;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign rom_data[g] = 4'(rom_adr[g]) + 4'd1;
    rom_sequencer #(.DIV(div_of(g)), .SUM_W(6)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start[g]),
      .stop      (stop[g]),
      .dir       (dir[g]),
      .loop      (loop[g]),
      .rom_adr   (rom_adr[g]),
      .rom_data  (rom_data[g]),
      .data_out  (data_out[g]),
      .data_valid(data_valid[g]),
      .sum       (sum[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, k, act, exp, $time);
  endtask

  // Model: position in the run is derived from cycles elapsed since start.
  bit                 m_run [NI];
  bit                 m_dir [NI];
  bit                 m_loop[NI];
  int                 m_n   [NI];
  logic [NI-1:0][2:0] e_adr;
  logic [NI-1:0][3:0] e_data;
  logic [NI-1:0]      e_valid, e_busy, e_done;
  logic [NI-1:0][5:0] e_sum;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NI; k++) begin
        m_run[k] = 0; m_dir[k] = 0; m_loop[k] = 0; m_n[k] = 0;
      end
      e_adr = '0; e_data = '0; e_valid = '0; e_busy = '0; e_done = '0; e_sum = '0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        e_valid[k] = 1'b0;
        e_done[k]  = 1'b0;
        if (!m_run[k]) begin
          if (start[k]) begin
            m_run[k] = 1; m_dir[k] = dir[k]; m_loop[k] = loop[k]; m_n[k] = 0;
            e_sum[k] = '0;
            e_adr[k] = dir[k] ? 3'd7 : 3'd0;
            e_busy[k] = 1'b1;
          end
        end else if (stop[k]) begin
          m_run[k] = 0;
          e_busy[k] = 1'b0;
        end else begin
          m_n[k]++;
          if (m_n[k] % div_of(k) == 0) begin
            int c, pos, a, npos;
            c    = m_n[k] / div_of(k);
            pos  = (c - 1) % 8;
            a    = m_dir[k] ? 7 - pos : pos;
            npos = c % 8;
            e_data[k]  = 4'(a + 1);
            e_valid[k] = 1'b1;
            e_sum[k]   = 6'((int'(e_sum[k]) + a + 1) % 64);
            e_adr[k]   = 3'(m_dir[k] ? 7 - npos : npos);
            if (npos == 0) begin
              e_done[k] = 1'b1;
              if (!m_loop[k]) begin
                m_run[k] = 0;
                e_busy[k] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      check("rom_adr",    k, int'(rom_adr[k]),    int'(e_adr[k]));
      check("data_out",   k, int'(data_out[k]),   int'(e_data[k]));
      check("data_valid", k, int'(data_valid[k]), int'(e_valid[k]));
      check("sum",        k, int'(sum[k]),        int'(e_sum[k]));
      check("busy",       k, int'(busy[k]),       int'(e_busy[k]));
      check("done",       k, int'(done[k]),       int'(e_done[k]));
    end
  end

  // Observation records used by the hand-computed checks.
  int cap[NI][$];
  int busy_cyc[NI];
  int done_cnt[NI];
  int vrun[NI];
  int vrun_max[NI];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (data_valid[k]) begin
        cap[k].push_back(int'(data_out[k]));
        vrun[k]++;
        if (vrun[k] > vrun_max[k]) vrun_max[k] = vrun[k];
      end else vrun[k] = 0;
      if (busy[k]) busy_cyc[k]++;
      if (done[k]) done_cnt[k]++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec(input int k);
    cap[k].delete();
    busy_cyc[k] = 0; done_cnt[k] = 0; vrun[k] = 0; vrun_max[k] = 0;
  endtask

  task automatic pulse_start(input int k, input bit d, input bit l);
    start[k] = 1'b1; dir[k] = d; loop[k] = l;
    tick();
    start[k] = 1'b0; dir[k] = ~d; loop[k] = ~l;
  endtask

  task automatic wait_done(input int k, input int limit, input string name);
    int seen = 0;
    for (int i = 0; i < limit; i++) begin
      if (done[k]) begin seen = 1; break; end
      tick();
    end
    check(name, k, seen, 1);
  endtask

  task automatic check_seq(input string name, input int k, input bit desc);
    check({name, "_count"}, k, cap[k].size(), 8);
    for (int i = 0; i < 8 && i < cap[k].size(); i++)
      check(name, k, cap[k][i], desc ? 8 - i : i + 1);
  endtask

  initial begin
    start = '0; stop = '0; dir = '0; loop = '0;
    reset = 1'b1;
    for (int k = 0; k < NI; k++) clear_rec(k);
    #1;
    check("reset_adr", 0, int'(rom_adr[0]), 0);
    check("reset_busy", 0, int'(busy[0]), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Ascending single pass, DIV=4.
    clear_rec(0);
    pulse_start(0, 1'b0, 1'b0);
    wait_done(0, 60, "t1_done_seen");
    check("t1_sum", 0, int'(sum[0]), 36);
    tick();
    check_seq("t1_seq", 0, 1'b0);
    check("t1_busy_cycles", 0, busy_cyc[0], 32);
    check("t1_done_count", 0, done_cnt[0], 1);
    check("t1_adr_end", 0, int'(rom_adr[0]), 0);
    check("t1_busy_end", 0, int'(busy[0]), 0);

    // Descending single pass, DIV=4.
    clear_rec(0);
    pulse_start(0, 1'b1, 1'b0);
    wait_done(0, 60, "t2_done_seen");
    check("t2_sum", 0, int'(sum[0]), 36);
    tick();
    check_seq("t2_seq", 0, 1'b1);
    check("t2_adr_end", 0, int'(rom_adr[0]), 7);

    // Looping, DIV=2: two passes then stop.
    clear_rec(1);
    pulse_start(1, 1'b0, 1'b1);
    for (int i = 0; i < 80 && cap[1].size() < 16; i++) tick();
    check("t3_captures", 1, cap[1].size(), 16);
    check("t3_done_count", 1, done_cnt[1], 2);
    check("t3_sum", 1, int'(sum[1]), 8);
    check("t3_busy", 1, int'(busy[1]), 1);
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    tick();
    check("t3_busy_after_stop", 1, int'(busy[1]), 0);

    // Stop coinciding with the third capture, DIV=4.
    clear_rec(0);
    pulse_start(0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) tick();
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    check("t4_data", 0, int'(data_out[0]), 2);
    check("t4_sum", 0, int'(sum[0]), 3);
    check("t4_adr", 0, int'(rom_adr[0]), 2);
    check("t4_busy", 0, int'(busy[0]), 0);
    for (int i = 0; i < 10; i++) tick();
    check("t4_captures", 0, cap[0].size(), 2);
    check("t4_done_count", 0, done_cnt[0], 0);

    // Asynchronous reset after five captures, then a clean pass.
    clear_rec(0);
    pulse_start(0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && cap[0].size() < 5; i++) tick();
    check("t5_captures", 0, cap[0].size(), 5);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_adr", 0, int'(rom_adr[0]), 0);
    check("t5_rst_data", 0, int'(data_out[0]), 0);
    check("t5_rst_sum", 0, int'(sum[0]), 0);
    check("t5_rst_busy", 0, int'(busy[0]), 0);
    check("t5_rst_valid", 0, int'(data_valid[0]), 0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("t5_done_count", 0, done_cnt[0], 0);
    clear_rec(0);
    pulse_start(0, 1'b0, 1'b0);
    wait_done(0, 60, "t5_done_seen");
    check("t5_sum", 0, int'(sum[0]), 36);
    tick();
    check_seq("t5_seq", 0, 1'b0);

    // DIV=1: continuous valid, start during RUN ignored.
    clear_rec(2);
    pulse_start(2, 1'b0, 1'b0);
    tick();
    pulse_start(2, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !done[2]; i++) tick();
    check("t6_done", 2, int'(done[2]), 1);
    check("t6_last_data", 2, int'(data_out[2]), 8);
    check("t6_sum", 2, int'(sum[2]), 36);
    tick(); tick(); tick();
    check_seq("t6_seq", 2, 1'b0);
    check("t6_valid_run", 2, vrun_max[2], 8);
    check("t6_done_count", 2, done_cnt[2], 1);
    check("t6_busy_end", 2, int'(busy[2]), 0);

    tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/rom_sequencer.md
Name: rom_sequencer

Overview:
- Address-generating stage that sits directly upstream of the 8-entry, 4-bit combinational lookup ROM.
- Steps the ROM address through one full pass, up or down, at a programmable rate.
- Registers each ROM word and keeps a running sum of the words it has read.
- Provides start/stop/busy/done control so a top-level controller or display stage can consume the results.

Parameters:
- DIV, 4, clock cycles per address step (≥1); 32-bit step counter.
- SUM_W, 6, width of the running-sum register; sum wraps modulo 2^SUM_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; sampled in IDLE only.
- stop  in  1  abort the current pass; sampled in RUN only.
- dir  in  1  0 = ascending (0→7), 1 = descending (7→0); latched on accepted start.
- loop  in  1  1 = restart the pass automatically at its end; latched on accepted start.
- rom_adr  out  3  address to the ROM; registered.
- rom_data  in  4  ROM word for rom_adr; combinational from the ROM.
- data_out  out  4  last captured ROM word.
- data_valid  out  1  one-cycle pulse; data_out updated this cycle.
- sum  out  SUM_W  running sum of captured words, modulo 2^SUM_W.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the final word of a pass is captured.

Behaviour:
- **Reset** (async, any state): state=IDLE; rom_adr=0, data_out=0, data_valid=0, sum=0, busy=0, done=0; step counter=0; latched dir and loop = 0.
- **States:** IDLE, RUN.
- **IDLE:**
  - start=1 → RUN at next edge.
  - Same edge: rom_adr = 0 if dir=0, else 7; sum=0; step counter=0; latch dir and loop.
  - stop is ignored in IDLE.
- **RUN step counter:** increments every cycle.
- **Capture** (step counter == DIV-1, with stop=0). At that edge:
  - data_out ← rom_data; data_valid=1 for the next cycle.
  - sum ← sum + rom_data (zero-extended, mod 2^SUM_W).
  - step counter ← 0.
  - rom_adr advances ±1 per latched dir.
- **First capture** happens DIV cycles after entry to RUN; one pass is 8×DIV cycles.
- **End of pass** (capture at address 7 ascending or 0 descending):
  - done=1 for the next cycle; rom_adr wraps (7→0 or 0→7).
  - loop=0: → IDLE, busy drops.
  - loop=1: stay in RUN, sum keeps accumulating (no clear), done pulses once per pass.
- **stop=1 in RUN** (priority over a coincident capture): → IDLE at next edge.
  - No capture and no done on that edge.
  - data_out, sum and rom_adr are held.
- **start while in RUN:** ignored. Changes to dir/loop in RUN are ignored (latched values are used).
- **Output timing:**
  - busy = (state==RUN), registered.
  - data_valid and done are registered single-cycle pulses, never asserted in IDLE except on the cycle immediately after the final capture.
- **DIV=1:** a capture occurs every RUN cycle; data_valid stays high continuously through the pass.
- **Reset mid-pass:** all outputs return to reset values immediately (asynchronous); no done pulse.

Test Plan:
- DIV=4, dir=0, loop=0, pulse start:
  - data_out sequence 1,2,…,8 with data_valid every 4th cycle.
  - done pulses once with sum=36; busy high for 32 cycles; then IDLE, rom_adr=0.
- DIV=4, dir=1, loop=0:
  - data_out sequence 8,7,…,1; final sum=36; rom_adr ends at 7.
- DIV=2, dir=0, loop=1, run 16 captures:
  - done pulses twice; sum=72 mod 64 = 8 after the second pass; busy stays high.
- DIV=4, dir=0: assert stop on the cycle of the 3rd capture:
  - data_out=2, sum=3, rom_adr=2, no further data_valid, no done, busy low.
- Assert reset mid-pass (after 5 captures):
  - all outputs 0 asynchronously; a subsequent start runs a clean pass with sum=36.
- DIV=1, dir=0, loop=0:
  - data_valid high for 8 consecutive cycles, data_out 1..8, done one cycle after the last capture; start asserted during RUN has no effect.
